// File: rtl/instruction_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory read
// handshake, applies redirects/holds and feeds the IF/ID pipeline register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        HOLD,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    output logic [31:0] INSTRUCTION_OUT,
    output logic [31:0] PC_DIRECT_OUT,
    output logic [31:0] PC_PLUS_4_OUT,
    output logic        FETCH_VALID,
    output logic        BUSYWAIT_OUT
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    logic [1:0]  state_reg;
    logic [31:0] pc_reg;
    logic        redirect_pending_reg;
    logic [31:0] redirect_addr_reg;
    logic [31:0] instr_reg;
    logic [31:0] pc_direct_reg;
    logic [31:0] pc_plus_4_reg;
    logic        valid_reg;

    logic [31:0] pc_plus_4;
    logic [31:0] redirect_target;
    logic        fetch_done;

    assign pc_plus_4 = pc_reg + 32'd4;
    // A live branch this cycle is younger than any remembered one, so it wins.
    assign redirect_target = (BRANCH_TAKEN ? BRANCH_TARGET : redirect_addr_reg) & ~32'd3;
    assign fetch_done      = (state_reg == ST_FETCH) && !IMEM_BUSYWAIT;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg            <= ST_IDLE;
            pc_reg               <= RESET_VECTOR;
            redirect_pending_reg <= 1'b0;
            redirect_addr_reg    <= 32'd0;
            instr_reg            <= NOP_INSTR;
            pc_direct_reg        <= 32'd0;
            pc_plus_4_reg        <= 32'd0;
            valid_reg            <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: state_reg <= ST_FETCH;
                ST_FETCH: begin
                    if (fetch_done) begin
                        if (BRANCH_TAKEN || redirect_pending_reg) begin
                            pc_reg               <= redirect_target;
                            redirect_pending_reg <= 1'b0;
                            instr_reg            <= NOP_INSTR;
                            valid_reg            <= 1'b0;
                        end else if (HOLD) begin
                            state_reg <= ST_STALL;
                        end else begin
                            instr_reg     <= IMEM_READDATA;
                            pc_direct_reg <= pc_reg;
                            pc_plus_4_reg <= pc_plus_4;
                            valid_reg     <= 1'b1;
                            pc_reg        <= pc_plus_4;
                        end
                    end else if (BRANCH_TAKEN) begin
                        // Request stays in flight; its data is dropped at completion.
                        redirect_addr_reg    <= BRANCH_TARGET;
                        redirect_pending_reg <= 1'b1;
                    end
                end
                ST_STALL: begin
                    if (BRANCH_TAKEN) begin
                        pc_reg    <= redirect_target;
                        instr_reg <= NOP_INSTR;
                        valid_reg <= 1'b0;
                        state_reg <= ST_FETCH;
                    end else if (!HOLD) begin
                        state_reg <= ST_FETCH;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign IMEM_READ       = (state_reg == ST_FETCH);
    assign IMEM_ADDRESS    = pc_reg;
    assign INSTRUCTION_OUT = instr_reg;
    assign PC_DIRECT_OUT   = pc_direct_reg;
    assign PC_PLUS_4_OUT   = pc_plus_4_reg;
    assign FETCH_VALID     = valid_reg;
    assign BUSYWAIT_OUT    = (state_reg == ST_IDLE)
                           || ((state_reg == ST_FETCH) && IMEM_BUSYWAIT
                               && !BRANCH_TAKEN && !redirect_pending_reg)
                           || HOLD;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RV  = 32'h00000000;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam int M_IDLE = 0, M_FETCH = 1, M_STALL = 2;

    logic        CLK = 1'b0;
    logic        RESET, BRANCH_TAKEN, HOLD, IMEM_BUSYWAIT;
    logic [31:0] BRANCH_TARGET, IMEM_READDATA;
    logic        IMEM_READ, FETCH_VALID, BUSYWAIT_OUT;
    logic [31:0] IMEM_ADDRESS, INSTRUCTION_OUT, PC_DIRECT_OUT, PC_PLUS_4_OUT;

    always #5 CLK = ~CLK;

    instruction_fetch_unit #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
        .CLK(CLK), .RESET(RESET), .BRANCH_TAKEN(BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET), .HOLD(HOLD),
        .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .IMEM_READ(IMEM_READ), .IMEM_ADDRESS(IMEM_ADDRESS),
        .INSTRUCTION_OUT(INSTRUCTION_OUT), .PC_DIRECT_OUT(PC_DIRECT_OUT),
        .PC_PLUS_4_OUT(PC_PLUS_4_OUT), .FETCH_VALID(FETCH_VALID),
        .BUSYWAIT_OUT(BUSYWAIT_OUT)
    );

    // Odd multiplier keeps every address mapping to a distinct word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h1;
    endfunction

    assign IMEM_READDATA = mem_word(IMEM_ADDRESS);

    int checks = 0;
    int failures = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    int          m_mode;
    logic        m_known = 1'b0;
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_redir_tgt;
    logic        m_valid, m_redir;

    task automatic model_update(input logic rst, input logic br, input logic [31:0] tgt,
                                input logic hold, input logic busy);
        logic [31:0] dest;
        if (!rst) begin
            m_known = 1'b1; m_mode = M_IDLE; m_pc = RV; m_redir = 1'b0; m_redir_tgt = 0;
            m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 1'b0;
            return;
        end
        if (!m_known) return;
        dest = br ? tgt : m_redir_tgt;
        dest = {dest[31:2], 2'b00};
        if (m_mode == M_IDLE) begin
            m_mode = M_FETCH;
        end else if (m_mode == M_STALL) begin
            if (br) begin
                m_pc = dest; m_instr = NOP; m_valid = 1'b0; m_mode = M_FETCH;
            end else if (!hold) m_mode = M_FETCH;
        end else if (busy) begin
            if (br) begin m_redir = 1'b1; m_redir_tgt = tgt; end
        end else if (br || m_redir) begin
            m_pc = dest; m_redir = 1'b0; m_instr = NOP; m_valid = 1'b0;
        end else if (hold) begin
            m_mode = M_STALL;
        end else begin
            m_instr = mem_word(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 32'd4;
            m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
    endtask

    // One clock: drive inputs, check combinational outputs, clock, check registers.
    task automatic step(input logic rst, input logic br, input logic [31:0] tgt,
                        input logic hold, input logic busy);
        logic exp_busy;
        RESET = rst; BRANCH_TAKEN = br; BRANCH_TARGET = tgt; HOLD = hold; IMEM_BUSYWAIT = busy;
        #1;
        if (m_known) begin
            exp_busy = (m_mode == M_IDLE) || (m_mode == M_FETCH && busy && !br && !m_redir) || hold;
            check_value("imem_read", IMEM_READ, m_mode == M_FETCH);
            check_value("imem_address", IMEM_ADDRESS, m_pc);
            check_value("busywait_out", BUSYWAIT_OUT, exp_busy);
        end
        @(posedge CLK);
        model_update(rst, br, tgt, hold, busy);
        #1;
        if (m_known) begin
            check_value("instruction_out", INSTRUCTION_OUT, m_instr);
            check_value("pc_direct_out", PC_DIRECT_OUT, m_pcd);
            check_value("pc_plus_4_out", PC_PLUS_4_OUT, m_pc4);
            check_value("fetch_valid", FETCH_VALID, m_valid);
        end
    endtask

    task automatic run_to(input logic [31:0] addr);
        int n = 0;
        while (m_pc != addr && n < 64) begin
            step(1, 0, 0, 0, 0);
            n++;
        end
        check_value("reach_addr", IMEM_ADDRESS, addr);
    endtask

    initial begin
        RESET = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 0; HOLD = 1'b0; IMEM_BUSYWAIT = 1'b0;

        step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        check_value("reset_valid", FETCH_VALID, 0);
        check_value("reset_instr", INSTRUCTION_OUT, NOP);
        check_value("reset_addr", IMEM_ADDRESS, RV);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_value("first_pc", PC_DIRECT_OUT, 32'h0);
        check_value("first_pc4", PC_PLUS_4_OUT, 32'h4);
        check_value("first_valid", FETCH_VALID, 1);
        $display("scenario free-run: first capture pc=%h", PC_DIRECT_OUT);

        run_to(32'h10);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 1);
            check_value("busy_addr_hold", IMEM_ADDRESS, 32'h10);
        end
        step(1, 0, 0, 0, 0);
        check_value("busy_capture_pc", PC_DIRECT_OUT, 32'h10);
        check_value("busy_next_addr", IMEM_ADDRESS, 32'h14);
        $display("scenario busywait: captured pc=%h", PC_DIRECT_OUT);

        run_to(32'h20);
        step(1, 1, 32'h103, 0, 0);
        check_value("branch_bubble", INSTRUCTION_OUT, NOP);
        check_value("branch_valid", FETCH_VALID, 0);
        check_value("branch_addr", IMEM_ADDRESS, 32'h100);
        $display("scenario branch: next addr=%h", IMEM_ADDRESS);

        step(1, 1, 32'h40, 0, 0);
        step(1, 1, 32'h200, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        check_value("late_redir_valid", FETCH_VALID, 0);
        check_value("late_redir_addr", IMEM_ADDRESS, 32'h200);
        $display("scenario pending redirect: next addr=%h", IMEM_ADDRESS);

        step(1, 1, 32'h80, 0, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        check_value("hold_read", IMEM_READ, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_value("hold_resume_pc", PC_DIRECT_OUT, 32'h80);
        step(1, 0, 0, 1, 0);
        step(1, 1, 32'h300, 1, 0);
        check_value("hold_branch_addr", IMEM_ADDRESS, 32'h300);
        check_value("hold_branch_valid", FETCH_VALID, 0);
        $display("scenario hold: redirect addr=%h", IMEM_ADDRESS);

        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check_value("midreq_reset_addr", IMEM_ADDRESS, RV);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 32'hFFFFFFFE, 0, 0);
        check_value("wrap_setup", IMEM_ADDRESS, 32'hFFFFFFFC);
        step(1, 0, 0, 0, 0);
        check_value("wrap_pc4", PC_PLUS_4_OUT, 32'h0);
        check_value("wrap_addr", IMEM_ADDRESS, 32'h0);
        $display("scenario wrap: pc=%h pc4=%h", PC_DIRECT_OUT, PC_PLUS_4_OUT);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | $urandom_range(0, 15)) : $urandom;
            step($urandom_range(0, 99) != 0, $urandom_range(0, 9) == 0, tgt,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 30);
        end
        $display("random phase done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
